// File: rtl/alarm_controller_pkg.sv
// Shared types and helpers for the alarm controller: FSM state encoding and the
// BCD time-field layout {HH, MM, SS, FF}.
package alarm_controller_pkg;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StRinging = 2'd1,
    StSnooze  = 2'd2
  } state_e;

  // HH [31:24], MM [23:16], SS [15:8], FF [7:0]; FF takes no part in the compare
  localparam int unsigned HhMsb = 31;
  localparam int unsigned SsLsb = 8;

  // True when HH:MM:SS and the PM flag agree; hundredths are ignored
  function automatic logic time_match(input logic [31:0] clock_time, input logic clock_pm,
                                      input logic [31:0] alarm_time, input logic alarm_pm);
    return (clock_time[HhMsb:SsLsb] == alarm_time[HhMsb:SsLsb]) && (clock_pm == alarm_pm);
  endfunction

endpackage

// File: rtl/alarm_controller_tick_generator.sv
// Modulo-DIVIDE counter: o_Tick is high for the last cycle of each interval and
// o_Count exposes the phase within the interval. i_Clear restarts the interval.
module alarm_controller_tick_generator #(
  parameter int unsigned DIVIDE = 2,
  localparam int unsigned CountW = (DIVIDE > 1) ? $clog2(DIVIDE) : 1
) (
  input  logic              i_Clk,
  input  logic              i_Reset,
  input  logic              i_Clear,
  output logic              o_Tick,
  output logic [CountW-1:0] o_Count
);

  logic [CountW-1:0] count_q;

  assign o_Tick  = (count_q == CountW'(DIVIDE - 1));
  assign o_Count = count_q;

  // Phase counter, wraps on the terminal count
  always_ff @(posedge i_Clk) begin
    if (i_Reset || i_Clear) begin
      count_q <= '0;
    end else if (o_Tick) begin
      count_q <= '0;
    end else begin
      count_q <= count_q + CountW'(1);
    end
  end

endmodule

// File: rtl/alarm_controller.sv
// Alarm ring/snooze controller: compares current time against the alarm setting,
// sequences IDLE/RINGING/SNOOZE and drives a cadenced buzzer tone.
module alarm_controller
  import alarm_controller_pkg::*;
#(
  parameter int unsigned CLK_HZ         = 5_000_000,
  parameter int unsigned TONE_HZ        = 2_000,
  parameter int unsigned RING_TIMEOUT_S = 60,
  parameter int unsigned SNOOZE_S       = 540,
  parameter int unsigned MAX_SNOOZES    = 3
) (
  input  logic        i_Clk_5MHz,
  input  logic        i_Reset,
  input  logic [31:0] i_Clock_Time,
  input  logic        i_Clock_PM,
  input  logic [31:0] i_Alarm_Time,
  input  logic        i_Alarm_PM,
  input  logic        i_Alarm_Enable,
  input  logic        i_Snooze,
  input  logic        i_Stop,
  output logic        o_Ringing,
  output logic        o_Snoozing,
  output logic        o_Buzzer,
  output logic [1:0]  o_Snooze_Count
);

  localparam int unsigned ToneDiv = CLK_HZ / (2 * TONE_HZ);
  localparam int unsigned PrescW  = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam int unsigned ToneW   = (ToneDiv > 1) ? $clog2(ToneDiv) : 1;
  localparam int unsigned SecMax  = (SNOOZE_S > RING_TIMEOUT_S) ? SNOOZE_S : RING_TIMEOUT_S;
  localparam int unsigned SecW    = $clog2(SecMax + 1);

  state_e            state_q, state_d;
  logic              match, match_q, trigger;
  logic              state_entry;
  logic              sec_tick;
  logic [PrescW-1:0] presc_count;
  logic              tone_tick, tone_q;
  logic [ToneW-1:0]  unused_tone_count;
  logic              unused_ff;
  logic [SecW-1:0]   sec_q, sec_next;
  logic              ring_expired, snooze_expired;
  logic [1:0]        snooze_cnt_q;
  logic              can_snooze, cadence;

  assign unused_ff = ^{i_Clock_Time[7:0], i_Alarm_Time[7:0]};

  assign match   = time_match(i_Clock_Time, i_Clock_PM, i_Alarm_Time, i_Alarm_PM);
  // Rising edge of the match gives exactly one trigger per matching second
  assign trigger = match && !match_q;

  // Second counter saturates; expiry looks at the value about to be registered so the
  // state leaves on the very tick that completes the interval
  assign sec_next       = (sec_q == '1) ? sec_q : sec_q + SecW'(1);
  assign ring_expired   = sec_tick && (sec_next == SecW'(RING_TIMEOUT_S));
  assign snooze_expired = sec_tick && (sec_next == SecW'(SNOOZE_S));

  assign can_snooze  = (snooze_cnt_q < 2'(MAX_SNOOZES));
  assign cadence     = (presc_count < PrescW'(CLK_HZ / 2));
  assign state_entry = (state_d != state_q);

  alarm_controller_tick_generator #(
    .DIVIDE (CLK_HZ)
  ) u_second_tick (
    .i_Clk   (i_Clk_5MHz),
    .i_Reset (i_Reset),
    .i_Clear (state_entry),
    .o_Tick  (sec_tick),
    .o_Count (presc_count)
  );

  alarm_controller_tick_generator #(
    .DIVIDE (ToneDiv)
  ) u_tone_tick (
    .i_Clk   (i_Clk_5MHz),
    .i_Reset (i_Reset),
    .i_Clear (1'b0),
    .o_Tick  (tone_tick),
    .o_Count (unused_tone_count)
  );

  // Next-state decode; priority is disable > stop > snooze > interval expiry
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle: begin
        if (trigger && i_Alarm_Enable) state_d = StRinging;
      end
      StRinging: begin
        if (!i_Alarm_Enable)              state_d = StIdle;
        else if (i_Stop)                  state_d = StIdle;
        else if (i_Snooze && can_snooze)  state_d = StSnooze;
        else if (ring_expired)            state_d = StIdle;
      end
      StSnooze: begin
        if (!i_Alarm_Enable)              state_d = StIdle;
        else if (i_Stop)                  state_d = StIdle;
        else if (snooze_expired)          state_d = StRinging;
      end
      default: state_d = StIdle;
    endcase
  end

  // Elapsed seconds in the current state, restarted on every state entry
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset || state_entry) begin
      sec_q <= '0;
    end else if (sec_tick) begin
      sec_q <= sec_next;
    end
  end

  // Buzzer square wave, free-running from reset
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      tone_q <= 1'b0;
    end else if (tone_tick) begin
      tone_q <= ~tone_q;
    end
  end

  // FSM state, match history, snooze count and registered status outputs
  always_ff @(posedge i_Clk_5MHz) begin
    if (i_Reset) begin
      state_q        <= StIdle;
      match_q        <= 1'b0;
      snooze_cnt_q   <= '0;
      o_Ringing      <= 1'b0;
      o_Snoozing     <= 1'b0;
      o_Buzzer       <= 1'b0;
      o_Snooze_Count <= '0;
    end else begin
      state_q <= state_d;
      match_q <= match;
      if (state_d == StIdle) begin
        snooze_cnt_q <= '0;
      end else if ((state_q == StRinging) && (state_d == StSnooze)) begin
        snooze_cnt_q <= snooze_cnt_q + 2'd1;
      end
      o_Ringing      <= (state_q == StRinging);
      o_Snoozing     <= (state_q == StSnooze);
      o_Buzzer       <= tone_q && cadence && (state_q == StRinging);
      o_Snooze_Count <= snooze_cnt_q;
    end
  end

endmodule

// File: tb/tb_alarm_controller.sv
// Directed bench for alarm_controller with a scaled-down clock (20 Hz, 5 Hz tone).
module tb_alarm_controller;

  localparam int unsigned ClkHz   = 20;
  localparam int unsigned ToneHz  = 5;
  localparam int unsigned RingS   = 3;
  localparam int unsigned SnoozeS = 2;
  localparam int unsigned MaxSnz  = 2;

  logic        clk;
  logic        i_Reset;
  logic [31:0] i_Clock_Time;
  logic        i_Clock_PM;
  logic [31:0] i_Alarm_Time;
  logic        i_Alarm_PM;
  logic        i_Alarm_Enable;
  logic        i_Snooze;
  logic        i_Stop;
  logic        o_Ringing;
  logic        o_Snoozing;
  logic        o_Buzzer;
  logic [1:0]  o_Snooze_Count;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int e;
  int s;
  logic exp_b;

  alarm_controller #(
    .CLK_HZ         (ClkHz),
    .TONE_HZ        (ToneHz),
    .RING_TIMEOUT_S (RingS),
    .SNOOZE_S       (SnoozeS),
    .MAX_SNOOZES    (MaxSnz)
  ) dut (
    .i_Clk_5MHz     (clk),
    .i_Reset        (i_Reset),
    .i_Clock_Time   (i_Clock_Time),
    .i_Clock_PM     (i_Clock_PM),
    .i_Alarm_Time   (i_Alarm_Time),
    .i_Alarm_PM     (i_Alarm_PM),
    .i_Alarm_Enable (i_Alarm_Enable),
    .i_Snooze       (i_Snooze),
    .i_Stop         (i_Stop),
    .o_Ringing      (o_Ringing),
    .o_Snoozing     (o_Snoozing),
    .o_Buzzer       (o_Buzzer),
    .o_Snooze_Count (o_Snooze_Count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Leave the matching second, come back to it; e is the edge where RINGING is entered
  task automatic ring_up(output int entry);
    i_Clock_Time = 32'h0730_0100;
    tick();
    i_Clock_Time = 32'h0730_0000;
    tick();
    entry = cyc;
    tick();
  endtask

  task automatic pulse_snooze();
    i_Snooze = 1'b1;
    tick();
    i_Snooze = 1'b0;
  endtask

  task automatic pulse_stop();
    i_Stop = 1'b1;
    tick();
    i_Stop = 1'b0;
  endtask

  initial begin
    i_Reset        = 1'b1;
    i_Clock_Time   = 32'h0729_5900;
    i_Clock_PM     = 1'b0;
    i_Alarm_Time   = 32'h0730_0000;
    i_Alarm_PM     = 1'b0;
    i_Alarm_Enable = 1'b1;
    i_Snooze       = 1'b0;
    i_Stop         = 1'b0;
    tick();
    tick();
    check("reset_ringing", o_Ringing, 0);
    check("reset_snoozing", o_Snoozing, 0);
    check("reset_buzzer", o_Buzzer, 0);
    check("reset_count", o_Snooze_Count, 0);
    i_Reset = 1'b0;
    cyc = 0;

    // 1. Trigger at 07:30:00 AM; output lags the state by one edge
    tick();
    tick();
    tick();
    check("idle_before_match", o_Ringing, 0);
    i_Clock_Time = 32'h0730_0000;
    tick();
    e = cyc;
    check("ring_lag", o_Ringing, 0);
    for (int k = 0; k < 20; k++) begin
      tick();
      if (k == 0) check("ring_on", o_Ringing, 1);
      // tone toggles every 2 edges from reset; cadence on for first 10 cycles of each second
      exp_b = ((((cyc - 1) / 2) % 2) == 1) && (((cyc - 1 - e) % 20) < 10);
      check("buzzer_pattern", o_Buzzer, exp_b);
    end

    // 2. Unanswered ring stops after exactly 3 s (60 cycles)
    while (cyc < e + 60) tick();
    check("ring_last_cycle", o_Ringing, 1);
    tick();
    check("ring_timeout", o_Ringing, 0);
    check("timeout_buzzer", o_Buzzer, 0);
    tick();
    tick();
    check("no_retrigger_held", o_Ringing, 0);

    // 3. Snooze twice, third snooze ignored
    ring_up(e);
    check("ring3", o_Ringing, 1);
    pulse_snooze();
    s = cyc;
    tick();
    check("snooze1_on", o_Snoozing, 1);
    check("snooze1_ring_off", o_Ringing, 0);
    check("snooze1_count", o_Snooze_Count, 1);
    check("snooze_buzzer", o_Buzzer, 0);
    while (cyc < s + 40) tick();
    check("snooze1_last", o_Snoozing, 1);
    tick();
    check("snooze1_rering", o_Ringing, 1);
    check("snooze1_off", o_Snoozing, 0);
    pulse_snooze();
    s = cyc;
    tick();
    check("snooze2_on", o_Snoozing, 1);
    check("snooze2_count", o_Snooze_Count, 2);
    while (cyc < s + 41) tick();
    check("snooze2_rering", o_Ringing, 1);
    pulse_snooze();
    tick();
    check("snooze3_ignored", o_Snoozing, 0);
    check("snooze3_still_ring", o_Ringing, 1);
    check("snooze3_count", o_Snooze_Count, 2);
    pulse_stop();
    tick();
    check("stop_idle", o_Ringing, 0);
    check("stop_count_clear", o_Snooze_Count, 0);

    // 4. Stop beats snooze in the same cycle
    ring_up(e);
    i_Snooze = 1'b1;
    i_Stop   = 1'b1;
    tick();
    i_Snooze = 1'b0;
    i_Stop   = 1'b0;
    tick();
    check("both_ring_off", o_Ringing, 0);
    check("both_no_snooze", o_Snoozing, 0);
    check("both_count", o_Snooze_Count, 0);

    // Disable cancels ringing
    ring_up(e);
    i_Alarm_Enable = 1'b0;
    tick();
    i_Alarm_Enable = 1'b1;
    tick();
    check("disable_cancels", o_Ringing, 0);

    // 5. PM mismatch, disabled alarm, time jump past alarm, hold after stop
    i_Clock_Time = 32'h0730_0100;
    tick();
    i_Clock_PM   = 1'b1;
    i_Clock_Time = 32'h0730_0000;
    tick();
    tick();
    check("pm_mismatch", o_Ringing, 0);
    i_Clock_PM   = 1'b0;
    i_Clock_Time = 32'h0730_0100;
    tick();
    i_Alarm_Enable = 1'b0;
    i_Clock_Time   = 32'h0730_0000;
    tick();
    tick();
    check("disabled_no_ring", o_Ringing, 0);
    i_Alarm_Enable = 1'b1;
    tick();
    tick();
    check("enable_mid_second", o_Ringing, 0);
    i_Clock_Time = 32'h0729_5900;
    tick();
    i_Clock_Time = 32'h0730_0200;
    tick();
    tick();
    check("jump_past", o_Ringing, 0);
    ring_up(e);
    pulse_stop();
    for (int k = 0; k < 40; k++) tick();
    check("held_after_stop", o_Ringing, 0);

    // 6. Reset during snooze
    ring_up(e);
    pulse_snooze();
    i_Clock_Time = 32'h0730_0500;
    tick();
    tick();
    check("pre_reset_snooze", o_Snoozing, 1);
    i_Reset = 1'b1;
    tick();
    i_Reset = 1'b0;
    check("rst_ringing", o_Ringing, 0);
    check("rst_snoozing", o_Snoozing, 0);
    check("rst_buzzer", o_Buzzer, 0);
    check("rst_count", o_Snooze_Count, 0);
    for (int k = 0; k < 50; k++) tick();
    check("rst_no_ring", o_Ringing, 0);
    check("rst_no_snooze", o_Snoozing, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
